// File: rtl/exec_pkg.sv
// Shared definitions for the execute cluster: opcodes, FU state encoding and
// the result record carried from each functional unit to the CDB arbiter.
package exec_pkg;

  localparam logic [3:0] OP_SUB = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  // Result fields are sized for the widest supported build (TAG_W <= 16,
  // DATA_W <= 64); narrower instances use the low bits only.
  localparam int RES_TAG_W  = 16;
  localparam int RES_DATA_W = 64;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_RUN  = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  typedef struct packed {
    logic [RES_TAG_W-1:0]  tag;
    logic [RES_DATA_W-1:0] data;
    logic                  err;
  } exec_result_t;

endpackage

// File: rtl/exec_fu.sv
// Non-pipelined functional unit: latches one operation, counts down LATENCY
// cycles and holds the result until the CDB takes it. EXEC_CLUSTER_DIV_EN enables division.
module exec_fu
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [TAG_W-1:0]  tag,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output exec_result_t      result
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  fu_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic [DATA_W-1:0] res_data;
  logic              res_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    case (state_q)
      FU_IDLE: begin
        if (start) begin
          op_d  = opcode;
          a_d   = src1;
          b_d   = src2;
          tag_d = tag;
          cnt_d = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? FU_DONE : FU_RUN;
        end
      end
      FU_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = FU_DONE;
        end
      end
      FU_DONE: begin
        if (ack) begin
          state_d = FU_IDLE;
        end
      end
      default: state_d = FU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  // Arithmetic works on the latched operands, so the result is stable in DONE.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_q)
      OP_SUB: res_data = a_q - b_q;
      OP_ADD: res_data = a_q + b_q;
      OP_MUL: res_data = a_q * b_q;
`ifdef EXEC_CLUSTER_DIV_EN
      OP_DIV: begin
        if (b_q == '0) begin
          res_data = '1;
          res_err  = 1'b1;
        end else begin
          res_data = a_q / b_q;
        end
      end
`else
      OP_DIV: res_err = 1'b1;
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    result                  = '0;
    result.tag[TAG_W-1:0]   = tag_q;
    result.data[DATA_W-1:0] = res_data;
    result.err              = res_err;
  end

  assign busy = (state_q != FU_IDLE);
  assign done = (state_q == FU_DONE);

endmodule

// File: rtl/exec_cluster.sv
// Execute stage: pairs ready RS entries with free FUs and arbitrates finished
// results round-robin onto one CDB port. Division is built only with EXEC_CLUSTER_DIV_EN.
module exec_cluster
  import exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int RS_DEPTH = 4,
  parameter int NUM_FU   = 2,
  parameter int LATENCY  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RS_DEPTH-1:0]        rs_ready,
  input  logic [4*RS_DEPTH-1:0]      rs_opcode,
  input  logic [DATA_W*RS_DEPTH-1:0] rs_src1,
  input  logic [DATA_W*RS_DEPTH-1:0] rs_src2,
  input  logic [TAG_W*RS_DEPTH-1:0]  rs_tag,
  output logic [RS_DEPTH-1:0]        rs_issue,
  output logic [NUM_FU-1:0]          fu_busy,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_err
);

  localparam int FU_IW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENT_IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [NUM_FU-1:0] fu_busy_raw;
  logic [NUM_FU-1:0] fu_done;
  logic [NUM_FU-1:0] fu_start;
  logic [NUM_FU-1:0] fu_ack;
  logic [NUM_FU-1:0] unused_res_bits;
  exec_result_t      fu_res [NUM_FU];
  logic [ENT_IW-1:0] fu_sel_ent [NUM_FU];

  logic [FU_IW-1:0]  ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic [FU_IW-1:0]  lock_idx_q, lock_idx_d;
  logic              grant_found;
  logic [FU_IW-1:0]  grant_idx;

  // Walk entries in index order, handing each ready one the lowest still-free FU.
  always_comb begin : dispatch_p
    logic [NUM_FU-1:0] avail;
    logic              claimed;
    rs_issue = '0;
    fu_start = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      fu_sel_ent[f] = '0;
    end
    avail   = ~fu_busy_raw;
    claimed = 1'b0;
    if (!rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        claimed = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
          if (rs_ready[i] && avail[f] && !claimed) begin
            claimed       = 1'b1;
            avail[f]      = 1'b0;
            rs_issue[i]   = 1'b1;
            fu_start[f]   = 1'b1;
            fu_sel_ent[f] = ENT_IW'(i);
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
      exec_fu #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .LATENCY (LATENCY)
      ) u_fu (
        .clk    (clk),
        .rst    (rst),
        .start  (fu_start[gi]),
        .opcode (rs_opcode[4*int'(fu_sel_ent[gi]) +: 4]),
        .src1   (rs_src1[DATA_W*int'(fu_sel_ent[gi]) +: DATA_W]),
        .src2   (rs_src2[DATA_W*int'(fu_sel_ent[gi]) +: DATA_W]),
        .tag    (rs_tag[TAG_W*int'(fu_sel_ent[gi]) +: TAG_W]),
        .ack    (fu_ack[gi]),
        .busy   (fu_busy_raw[gi]),
        .done   (fu_done[gi]),
        .result (fu_res[gi])
      );
      assign fu_ack[gi]          = cdb_valid && cdb_ready && (grant_idx == FU_IW'(gi));
      assign unused_res_bits[gi] = ^fu_res[gi];
    end
  endgenerate

  // A stalled grant is pinned so a later finisher cannot steal the bus mid-handshake.
  always_comb begin : arbiter_p
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (lock_q && fu_done[lock_idx_q]) begin
      grant_found = 1'b1;
      grant_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= NUM_FU) begin
          cand = cand - NUM_FU;
        end
        if (!grant_found && fu_done[cand]) begin
          grant_found = 1'b1;
          grant_idx   = FU_IW'(cand);
        end
      end
    end
  end

  always_comb begin
    cdb_valid = grant_found && !rst;
    cdb_tag   = '0;
    cdb_data  = '0;
    cdb_err   = 1'b0;
    if (cdb_valid) begin
      cdb_tag  = fu_res[grant_idx].tag[TAG_W-1:0];
      cdb_data = fu_res[grant_idx].data[DATA_W-1:0];
      cdb_err  = fu_res[grant_idx].err;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = cdb_valid && !cdb_ready;
    lock_idx_d = grant_idx;
    if (cdb_valid && cdb_ready) begin
      ptr_d = (grant_idx == FU_IW'(NUM_FU - 1)) ? '0 : grant_idx + FU_IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign fu_busy = rst ? '0 : fu_busy_raw;

endmodule

// File: tb/tb_exec_cluster.sv
// Scoreboard bench for exec_cluster: stimulus pushes expected CDB results,
// a monitor pops and compares on every accepted CDB transfer.
module tb_exec_cluster;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int RD = 4;
  localparam int NF = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [RD-1:0]   rs_ready = '0;
  logic [4*RD-1:0] rs_opcode = '0;
  logic [DW*RD-1:0] rs_src1 = '0;
  logic [DW*RD-1:0] rs_src2 = '0;
  logic [TW*RD-1:0] rs_tag = '0;
  logic [RD-1:0]   rs_issue;
  logic [NF-1:0]   fu_busy;
  logic            cdb_valid;
  logic            cdb_ready = 1'b1;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            cdb_err;

  logic [RD-1:0]   iss;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exec_cluster #(
    .DATA_W   (DW),
    .TAG_W    (TW),
    .RS_DEPTH (RD),
    .NUM_FU   (NF),
    .LATENCY  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs_ready  (rs_ready),
    .rs_opcode (rs_opcode),
    .rs_src1   (rs_src1),
    .rs_src2   (rs_src2),
    .rs_tag    (rs_tag),
    .rs_issue  (rs_issue),
    .fu_busy   (fu_busy),
    .cdb_valid (cdb_valid),
    .cdb_ready (cdb_ready),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_err   (cdb_err)
  );

  // Monitor: every accepted CDB transfer must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cdb_valid && cdb_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cdb_unexpected: got tag %0h data %h err %0b, required no result",
                 cdb_tag, cdb_data, cdb_err);
      end else begin
        e = exp_q.pop_front();
        if ({cdb_tag, cdb_data, cdb_err} !== {e.tag, e.data, e.err}) begin
          n_err++;
          $display("FAIL cdb_result: got tag %0h data %h err %0b, required tag %0h data %h err %0b",
                   cdb_tag, cdb_data, cdb_err, e.tag, e.data, e.err);
        end else begin
          $display("cdb tag %0h data %h err %0b", cdb_tag, cdb_data, cdb_err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Call at a negedge: takes the clock edge and retires issued RS entries.
  task automatic pos();
    iss = rs_issue;
    @(posedge clk);
    #1;
    rs_ready = rs_ready & ~iss;
  endtask

  task automatic step();
    @(negedge clk);
    pos();
  endtask

  task automatic set_entry(input int i, input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] t);
    rs_opcode[4*i +: 4] = op;
    rs_src1[DW*i +: DW] = a;
    rs_src2[DW*i +: DW] = b;
    rs_tag[TW*i +: TW]  = t;
    rs_ready[i]         = 1'b1;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.tag  = t;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic single(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] t, input logic [DW-1:0] d, input logic e);
    set_entry(0, op, a, b, t);
    push(t, d, e);
    drain("single");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with an entry already ready: nothing may issue while rst is high.
    set_entry(0, 4'b0001, 32'd5, 32'd3, 4'd1);
    @(negedge clk);
    check("rst_issue", rs_issue, 4'b0000);
    check("rst_busy", fu_busy, 2'b00);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_cdb", {cdb_tag, cdb_data, cdb_err}, '0);
    pos();
    step();
    rst = 1'b0;

    // 5+3 tag 1: issue now, cdb_valid exactly three cycles later for one cycle.
    push(4'd1, 32'd8, 1'b0);
    @(negedge clk);
    check("t1_issue", rs_issue, 4'b0001);
    check("t1_busy0", fu_busy, 2'b00);
    pos();
    @(negedge clk);
    check("t1_busy1", fu_busy, 2'b01);
    check("t1_valid1", cdb_valid, 1'b0);
    check("t1_noissue", rs_issue, 4'b0000);
    pos();
    @(negedge clk);
    check("t1_valid2", cdb_valid, 1'b0);
    pos();
    @(negedge clk);
    check("t1_valid3", cdb_valid, 1'b1);
    pos();
    @(negedge clk);
    check("t1_valid4", cdb_valid, 1'b0);
    check("t1_busy4", fu_busy, 2'b00);
    pos();
    drain("t1");

    // Three ready entries, two FUs: entry 2 waits for the first acceptance.
    do_reset();
    set_entry(0, 4'b0000, 32'd9, 32'd4, 4'd2);
    set_entry(1, 4'b0001, 32'd1, 32'd1, 4'd3);
    set_entry(2, 4'b0010, 32'd6, 32'd7, 4'd4);
    push(4'd2, 32'd5, 1'b0);
    push(4'd3, 32'd2, 1'b0);
    push(4'd4, 32'h2A, 1'b0);
    @(negedge clk);
    check("t2_issue0", rs_issue, 4'b0011);
    pos();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t2_wait", rs_issue, 4'b0000);
      pos();
    end
    @(negedge clk);
    check("t2_issue4", rs_issue, 4'b0100);
    pos();
    drain("t2");

    // Back-pressure: two results held for four cycles, then FU0, FU1.
    do_reset();
    cdb_ready = 1'b0;
    set_entry(0, 4'b0001, 32'd10, 32'd20, 4'd5);
    set_entry(1, 4'b0000, 32'd100, 32'd1, 4'd6);
    push(4'd5, 32'h1E, 1'b0);
    push(4'd6, 32'h63, 1'b0);
    push(4'd7, 32'd4, 1'b0);
    @(negedge clk);
    check("t3_issue0", rs_issue, 4'b0011);
    pos();
    set_entry(2, 4'b0001, 32'd2, 32'd2, 4'd7);
    step();
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_hold_valid", cdb_valid, 1'b1);
      check("t3_hold_tag", cdb_tag, 4'd5);
      check("t3_hold_data", cdb_data, 32'h1E);
      check("t3_hold_busy", fu_busy, 2'b11);
      check("t3_hold_issue", rs_issue, 4'b0000);
      pos();
    end
    cdb_ready = 1'b1;
    @(negedge clk);
    check("t3_rel_issue", rs_issue, 4'b0000);
    pos();
    @(negedge clk);
    check("t3_issue2", rs_issue, 4'b0100);
    pos();
    drain("t3a");
    // Pointer now sits at FU1, so the next simultaneous pair goes FU1 first.
    set_entry(0, 4'b0001, 32'd1, 32'd2, 4'd8);
    set_entry(1, 4'b0001, 32'd3, 32'd4, 4'd9);
    push(4'd9, 32'd7, 1'b0);
    push(4'd8, 32'd3, 1'b0);
    @(negedge clk);
    check("t3_pair_issue", rs_issue, 4'b0011);
    pos();
    drain("t3b");

`ifdef EXEC_CLUSTER_DIV_EN
    single(4'b0011, 32'd10, 32'd0, 4'd10, 32'hFFFFFFFF, 1'b1);
    single(4'b0011, 32'd100, 32'd7, 4'd11, 32'd14, 1'b0);
`else
    single(4'b0011, 32'd10, 32'd2, 4'd10, 32'd0, 1'b1);
`endif
    single(4'b0111, 32'd3, 32'd4, 4'd12, 32'd0, 1'b1);
    single(4'b0001, 32'h7FFFFFFF, 32'd1, 4'd13, 32'h80000000, 1'b0);
    single(4'b0000, 32'd0, 32'd1, 4'd14, 32'hFFFFFFFF, 1'b0);
    single(4'b0010, 32'hFFFFFFFF, 32'd2, 4'd15, 32'hFFFFFFFE, 1'b0);

    // Reset while FU0 holds a result and FU1 is still running: both discarded.
    cdb_ready = 1'b0;
    set_entry(0, 4'b0001, 32'd1, 32'd1, 4'd1);
    @(negedge clk);
    check("t6_issue0", rs_issue, 4'b0001);
    pos();
    set_entry(1, 4'b0001, 32'd2, 32'd2, 4'd2);
    @(negedge clk);
    check("t6_issue1", rs_issue, 4'b0010);
    pos();
    @(negedge clk);
    check("t6_busy", fu_busy, 2'b11);
    pos();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", fu_busy, 2'b00);
    check("t6_rst_valid", cdb_valid, 1'b0);
    pos();
    rst = 1'b0;
    cdb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_post_valid", cdb_valid, 1'b0);
      check("t6_post_busy", fu_busy, 2'b00);
      pos();
    end
    single(4'b0001, 32'd20, 32'd22, 4'd3, 32'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
